// File: rtl/instr_decoder_pkg.sv
// instr_decoder_pkg: register IDs, instruction classes, trap states and the
// monitor-trap NOP sequence shared by the decoder and its trap FSM.
package instr_decoder_pkg;
    localparam int REG_X0 = 0;
    localparam int REG_X1 = 1;
    localparam int REG_Y0 = 2;
    localparam int REG_Y1 = 3;
    localparam int REG_R  = 4;
    localparam int REG_M  = 5;
    localparam int REG_I  = 6;
    localparam int REG_DM = 7;
    localparam int REG_O  = 8;
    // Field code 4 reads r as a source but writes o as a destination.
    localparam int FLD_RO = 4;
    localparam logic [3:0] SRC_NONE  = 4'd8;
    localparam logic [3:0] SRC_SELF  = 4'd9;
    localparam logic [3:0] SRC_RESET = 4'd10;

    typedef enum logic [2:0] {CLS_LOAD, CLS_MOVE, CLS_ALU, CLS_JUMP, CLS_CJUMP} instr_class_t;
    typedef enum logic [1:0] {T_IDLE, T_S1, T_S2, T_S3} trap_state_t;

    localparam logic [3:0][7:0] NOP_SEQ = {8'hDF, 8'hD8, 8'hCF, 8'hC8};

    function automatic instr_class_t classify(input logic [7:0] i);
        return !i[7] ? CLS_LOAD : !i[6] ? CLS_MOVE : !i[5] ? CLS_ALU : !i[4] ? CLS_JUMP : CLS_CJUMP;
    endfunction

    function automatic logic [8:0] reg_bit(input int id);
        return 9'(1) << id;
    endfunction
endpackage

// File: rtl/instr_decoder_p_trap.sv
// monitor_trap_fsm: tracks the NOP trap sequence over live instructions and
// emits a one-cycle jump_to_monitor pulse plus a saturating trap count.
module monitor_trap_fsm
    import instr_decoder_pkg::*;
#(
    parameter int TRAP_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [7:0]       ir,
    input  logic             ir_valid,
    input  logic             hold,
    output logic             jump_to_monitor,
    output logic [CNT_W-1:0] trap_count
);
    trap_state_t state;
    logic match;
    logic done;
    trap_state_t restart;

    assign match   = ir == NOP_SEQ[state];
    assign done    = match && (int'(state) + 1 == TRAP_LEN);
    // A broken sequence may itself be the start of a new one.
    assign restart = (ir == NOP_SEQ[0] && TRAP_LEN > 1) ? T_S1 : T_IDLE;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state           <= T_IDLE;
            jump_to_monitor <= 1'b0;
            trap_count      <= '0;
        end else if (!hold) begin
            jump_to_monitor <= ir_valid && done;
            if (ir_valid) begin
                state <= done ? T_IDLE : match ? trap_state_t'(state + 2'd1) : restart;
                if (done && trap_count != '1) trap_count <= trap_count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/instr_decoder_p.sv
// instr_decoder_p: registers the fetched instruction under valid/hold, flushes
// the slot after a taken jump and decodes datapath selects and register enables.
module instr_decoder_p
    import instr_decoder_pkg::*;
#(
    parameter int TRAP_LEN     = 4,
    parameter int FLUSH_ON_JMP = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [7:0]       next_instr,
    input  logic             instr_valid,
    input  logic             hold,
    input  logic             alu_nz,
    output logic [7:0]       ir,
    output logic             ir_valid,
    output logic             jmp,
    output logic             jmp_nz,
    output logic [3:0]       ir_nibble,
    output logic             i_sel,
    output logic             x_sel,
    output logic             y_sel,
    output logic [3:0]       source_sel,
    output logic [8:0]       reg_en,
    output logic             jump_to_monitor,
    output logic [CNT_W-1:0] trap_count
);
    instr_class_t cls;
    logic flush;
    logic is_ld;
    logic is_mv;
    logic is_alu;
    int ld_dst;
    int mv_dst;
    int src;
    logic [8:0] ld_en;
    logic [8:0] mv_en;
    logic [3:0] mv_sel;

    assign flush = FLUSH_ON_JMP != 0 && ir_valid && (jmp || (jmp_nz && alu_nz));

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            ir       <= 8'h00;
            ir_valid <= 1'b0;
        end else if (!hold) begin
            ir       <= next_instr;
            ir_valid <= instr_valid && !flush;
        end
    end

    assign cls    = classify(ir);
    assign is_ld  = ir_valid && cls == CLS_LOAD;
    assign is_mv  = ir_valid && cls == CLS_MOVE;
    assign is_alu = ir_valid && cls == CLS_ALU;
    assign ld_dst = int'(ir[6:4]);
    assign mv_dst = int'(ir[5:3]);
    assign src    = int'(ir[2:0]);

    assign ld_en = ld_dst == REG_DM ? reg_bit(REG_DM) | reg_bit(REG_I)
                 : ld_dst == FLD_RO ? reg_bit(REG_O) : reg_bit(ld_dst);
    assign mv_en = (mv_dst == FLD_RO && src == REG_I) ? reg_bit(REG_O)
                 : (mv_dst == REG_DM || (src == REG_DM && mv_dst != REG_I)) ? reg_bit(mv_dst) | reg_bit(REG_I)
                 : mv_dst == FLD_RO ? reg_bit(REG_O) : reg_bit(mv_dst);
    assign mv_sel = (src == FLD_RO && mv_dst == FLD_RO) ? 4'(FLD_RO)
                  : src == mv_dst ? SRC_SELF : {1'b0, ir[2:0]};

    assign ir_nibble  = ir[3:0];
    assign jmp        = !sync_reset && ir_valid && cls == CLS_JUMP;
    assign jmp_nz     = !sync_reset && ir_valid && cls == CLS_CJUMP;
    assign i_sel      = !sync_reset && !((is_ld && ld_dst == REG_I) || (is_mv && mv_dst == REG_I));
    assign x_sel      = !sync_reset && ir[4];
    assign y_sel      = !sync_reset && ir[3];
    assign source_sel = sync_reset ? SRC_RESET : is_mv ? mv_sel : SRC_NONE;
    assign reg_en     = sync_reset ? 9'h1FF : is_ld ? ld_en : is_mv ? mv_en : is_alu ? reg_bit(REG_R) : 9'h000;

    monitor_trap_fsm #(.TRAP_LEN(TRAP_LEN), .CNT_W(CNT_W)) u_trap (
        .clk(clk),
        .sync_reset(sync_reset),
        .ir(ir),
        .ir_valid(ir_valid),
        .hold(hold),
        .jump_to_monitor(jump_to_monitor),
        .trap_count(trap_count)
    );
endmodule

// File: tb/tb_instr_decoder_p.sv
// tb_instr_decoder_p: table-driven decode vectors through a scoreboard queue,
// plus hand-written trap, hold, saturation and reset sequences.
module tb_instr_decoder_p;
    logic clk = 1'b0;
    logic sync_reset = 1'b1;
    logic [7:0] next_instr = 8'hA5;
    logic instr_valid = 1'b1;
    logic hold = 1'b0;
    logic alu_nz = 1'b0;

    // Instances: 0 default, 1 no flush, 2 CNT_W=2, 3 TRAP_LEN=2.
    logic [7:0] ir [4];
    logic ir_valid [4];
    logic jmp [4];
    logic jmp_nz [4];
    logic [3:0] ir_nibble [4];
    logic i_sel [4];
    logic x_sel [4];
    logic y_sel [4];
    logic [3:0] source_sel [4];
    logic [8:0] reg_en [4];
    logic jtm [4];
    logic [7:0] cnt0, cnt1, cnt3;
    logic [1:0] cnt2;

    instr_decoder_p dut (.clk(clk), .sync_reset(sync_reset), .next_instr(next_instr), .instr_valid(instr_valid),
        .hold(hold), .alu_nz(alu_nz), .ir(ir[0]), .ir_valid(ir_valid[0]), .jmp(jmp[0]), .jmp_nz(jmp_nz[0]),
        .ir_nibble(ir_nibble[0]), .i_sel(i_sel[0]), .x_sel(x_sel[0]), .y_sel(y_sel[0]), .source_sel(source_sel[0]),
        .reg_en(reg_en[0]), .jump_to_monitor(jtm[0]), .trap_count(cnt0));
    instr_decoder_p #(.FLUSH_ON_JMP(0)) dut_nf (.clk(clk), .sync_reset(sync_reset), .next_instr(next_instr),
        .instr_valid(instr_valid), .hold(hold), .alu_nz(alu_nz), .ir(ir[1]), .ir_valid(ir_valid[1]), .jmp(jmp[1]),
        .jmp_nz(jmp_nz[1]), .ir_nibble(ir_nibble[1]), .i_sel(i_sel[1]), .x_sel(x_sel[1]), .y_sel(y_sel[1]),
        .source_sel(source_sel[1]), .reg_en(reg_en[1]), .jump_to_monitor(jtm[1]), .trap_count(cnt1));
    instr_decoder_p #(.CNT_W(2)) dut_c2 (.clk(clk), .sync_reset(sync_reset), .next_instr(next_instr),
        .instr_valid(instr_valid), .hold(hold), .alu_nz(alu_nz), .ir(ir[2]), .ir_valid(ir_valid[2]), .jmp(jmp[2]),
        .jmp_nz(jmp_nz[2]), .ir_nibble(ir_nibble[2]), .i_sel(i_sel[2]), .x_sel(x_sel[2]), .y_sel(y_sel[2]),
        .source_sel(source_sel[2]), .reg_en(reg_en[2]), .jump_to_monitor(jtm[2]), .trap_count(cnt2));
    instr_decoder_p #(.TRAP_LEN(2)) dut_t2 (.clk(clk), .sync_reset(sync_reset), .next_instr(next_instr),
        .instr_valid(instr_valid), .hold(hold), .alu_nz(alu_nz), .ir(ir[3]), .ir_valid(ir_valid[3]), .jmp(jmp[3]),
        .jmp_nz(jmp_nz[3]), .ir_nibble(ir_nibble[3]), .i_sel(i_sel[3]), .x_sel(x_sel[3]), .y_sel(y_sel[3]),
        .source_sel(source_sel[3]), .reg_en(reg_en[3]), .jump_to_monitor(jtm[3]), .trap_count(cnt3));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic prev_jtm = 1'b0;

    always @(negedge clk) begin
        if (jtm[0] && !prev_jtm) pulses++;
        prev_jtm = jtm[0];
    end

    typedef struct {
        logic [7:0] instr;
        logic       valid;
        logic       nz;
        logic       v;
        logic [8:0] en;
        logic [8:0] nf_en;
        logic [3:0] ss;
        logic       i, x, y, j, jn;
    } vec_t;

    vec_t tbl [19];
    vec_t sb [$];
    vec_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] ins, input logic v);
        next_instr = ins;
        instr_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{8'h72, 1'b1, 1'b0, 1'b1, 9'h0C0, 9'h0C0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'h63, 1'b1, 1'b0, 1'b1, 9'h040, 9'h040, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'hA4, 1'b1, 1'b0, 1'b1, 9'h100, 9'h100, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 9'h100, 9'h100, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'hAD, 1'b1, 1'b0, 1'b1, 9'h020, 9'h020, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{8'hA6, 1'b1, 1'b0, 1'b1, 9'h100, 9'h100, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8'hBA, 1'b1, 1'b0, 1'b1, 9'h0C0, 9'h0C0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{8'hB7, 1'b1, 1'b0, 1'b1, 9'h040, 9'h040, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h8F, 1'b1, 1'b0, 1'b1, 9'h042, 9'h042, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{8'hC3, 1'b1, 1'b0, 1'b1, 9'h010, 9'h010, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{8'h5A, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{8'h40, 1'b1, 1'b0, 1'b1, 9'h100, 9'h100, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{8'hF1, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{8'h12, 1'b1, 1'b0, 1'b1, 9'h002, 9'h002, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{8'hF1, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{8'h12, 1'b1, 1'b1, 1'b0, 9'h000, 9'h002, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{8'hE3, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{8'h12, 1'b1, 1'b0, 1'b0, 9'h000, 9'h002, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{8'h12, 1'b1, 1'b0, 1'b1, 9'h002, 9'h002, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with a live instruction on the bus.
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_en", 32'(reg_en[0]), 32'h1FF);
        check("rst_source_sel", 32'(source_sel[0]), 32'd10);
        check("rst_sels", {jmp[0], jmp_nz[0], i_sel[0], x_sel[0], y_sel[0]}, 32'd0);
        check("rst_ir_valid", 32'(ir_valid[0]), 32'd0);
        check("rst_trap", {jtm[0], cnt0}, 32'd0);
        sync_reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ir", 32'(ir[0]), 32'hA5);
        check("post_rst_valid", 32'(ir_valid[0]), 32'd1);
        check("post_rst_reg_en", 32'(reg_en[0]), 32'h100);
        check("post_rst_source_sel", 32'(source_sel[0]), 32'd5);

        for (int k = 0; k < 19; k++) begin
            next_instr = tbl[k].instr;
            instr_valid = tbl[k].valid;
            alu_nz = tbl[k].nz;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d_ir", k), 32'(ir[0]), 32'(e.instr));
            check($sformatf("v%0d_ir_valid", k), 32'(ir_valid[0]), 32'(e.v));
            check($sformatf("v%0d_reg_en", k), 32'(reg_en[0]), 32'(e.en));
            check($sformatf("v%0d_source_sel", k), 32'(source_sel[0]), 32'(e.ss));
            check($sformatf("v%0d_sels", k), {i_sel[0], x_sel[0], y_sel[0], jmp[0], jmp_nz[0]},
                  {e.i, e.x, e.y, e.j, e.jn});
            check($sformatf("v%0d_nibble", k), 32'(ir_nibble[0]), 32'(e.instr[3:0]));
            check($sformatf("v%0d_noflush_reg_en", k), 32'(reg_en[1]), 32'(e.nf_en));
        end
        alu_nz = 1'b0;

        // Trap with a bubble inside the sequence.
        send(8'hC8, 1'b1); send(8'hCF, 1'b1); send(8'h00, 1'b0); send(8'hD8, 1'b1); send(8'hDF, 1'b1);
        check("seq1_early", 32'(jtm[0]), 32'd0);
        send(8'h00, 1'b1);
        check("seq1_pulse", 32'(jtm[0]), 32'd1);
        check("seq1_count", 32'(cnt0), 32'd1);
        send(8'h00, 1'b1);
        check("seq1_pulse_end", 32'(jtm[0]), 32'd0);

        // Broken sequence restarting on C8 yields one trap.
        send(8'hC8, 1'b1); send(8'hCF, 1'b1); send(8'hC8, 1'b1); send(8'hCF, 1'b1); send(8'hD8, 1'b1);
        send(8'hDF, 1'b1);
        check("seq2_early", 32'(jtm[0]), 32'd0);
        send(8'h00, 1'b1);
        check("seq2_pulse", 32'(jtm[0]), 32'd1);
        check("seq2_count", 32'(cnt0), 32'd2);
        send(8'h00, 1'b1);
        check("seq2_pulse_end", 32'(jtm[0]), 32'd0);

        // Hold mid-sequence, then hold while the pulse is high.
        send(8'hC8, 1'b1); send(8'hCF, 1'b1);
        hold = 1'b1;
        next_instr = 8'hD8;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_ir", k), 32'(ir[0]), 32'hCF);
            check($sformatf("hold%0d_reg_en", k), 32'(reg_en[0]), 32'h010);
        end
        hold = 1'b0;
        send(8'hD8, 1'b1); send(8'hDF, 1'b1);
        check("hold_seq_early", 32'(jtm[0]), 32'd0);
        send(8'h00, 1'b1);
        check("hold_seq_pulse", 32'(jtm[0]), 32'd1);
        check("hold_seq_count", 32'(cnt0), 32'd3);
        hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pulse_hold%0d", k), 32'(jtm[0]), 32'd1);
            check($sformatf("pulse_hold%0d_count", k), 32'(cnt0), 32'd3);
        end
        hold = 1'b0;
        send(8'h00, 1'b1);
        check("pulse_hold_end", 32'(jtm[0]), 32'd0);

        // Two more traps: CNT_W=2 saturates at 3.
        for (int k = 0; k < 2; k++) begin
            send(8'hC8, 1'b1); send(8'hCF, 1'b1); send(8'hD8, 1'b1); send(8'hDF, 1'b1); send(8'h00, 1'b1);
        end
        send(8'h00, 1'b1);
        check("count_default", 32'(cnt0), 32'd5);
        check("count_saturated", 32'(cnt2), 32'd3);
        check("count_trap_len2", 32'(cnt3), 32'd6);
        check("pulse_edges", 32'(pulses), 32'd5);

        // Reset mid-sequence discards the partial match.
        send(8'hC8, 1'b1); send(8'hCF, 1'b1); send(8'hD8, 1'b1);
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        check("mid_rst_count", 32'(cnt0), 32'd0);
        send(8'hDF, 1'b1); send(8'h00, 1'b1);
        check("mid_rst_no_pulse0", 32'(jtm[0]), 32'd0);
        send(8'h00, 1'b1);
        check("mid_rst_no_pulse1", 32'(jtm[0]), 32'd0);
        check("mid_rst_count_after", 32'(cnt0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
